// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one bit per clk, start/data/[parity]/stop framing.
// Busy leads the start bit by one LOAD cycle so a downstream RX can align.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t                state, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CW-1:0]         cnt, cnt_d;
    logic                  par_en_q, par_typ_q, par_bit;
    logic                  accept;
    logic                  tx_d, busy_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bit   <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            TX_OUT <= tx_d;
            Busy   <= busy_d;
            if (accept) begin
                data_q    <= P_DATA;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            if (state == LOAD)
                par_bit <= par_typ_q ? ~^data_q : ^data_q;
        end
    end

    // Outputs are registered from the next state, so TX_OUT/Busy
    // change on the same edge that enters each state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = 1'b0;
        tx_d    = 1'b1;
        busy_d  = 1'b1;
        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    accept  = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = START;
            end
            START: state_d = DATA;
            DATA: begin
                if (cnt == LAST)
                    state_d = par_en_q ? PARITY : STOP;
                else
                    cnt_d = cnt + CW'(1);
            end
            PARITY: state_d = STOP;
            STOP:   state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        case (state_d)
            IDLE:    busy_d = 1'b0;
            START:   tx_d   = 1'b0;
            DATA:    tx_d   = data_q[cnt_d];
            PARITY:  tx_d   = par_bit;
            default: tx_d   = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed frame vectors plus corner sequences and a decoding RX model
// for the UART transmit serializer.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       Busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    // exp_bits: TX_OUT per Busy-high cycle, LSB = LOAD cycle
    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        pt;
        logic [15:0] exp_bits;
        int          exp_len;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Samples each negedge while Busy is high; ends on the first idle cycle.
    task automatic capture(output logic [15:0] bits, output int len);
        bits = '0;
        len  = 0;
        while (Busy && len < 16) begin
            bits[len] = TX_OUT;
            len++;
            @(negedge clk);
        end
        check("idle_tx_high", {31'd0, TX_OUT}, 32'd1);
    endtask

    // Pulses DATA_VALID for one edge, then scrambles inputs mid-frame.
    task automatic run_frame(input logic [7:0] d, input logic pe,
                             input logic pt, output logic [15:0] bits,
                             output int len);
        @(negedge clk);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        capture(bits, len);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] bits;
        int          len;
        logic [7:0]  d;
        logic        pe, pt;

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 16'h0695, 11};
        tbl[1] = '{8'h3C, 1'b1, 1'b0, 16'h08F1, 12};
        tbl[2] = '{8'h3C, 1'b1, 1'b1, 16'h0CF1, 12};
        tbl[3] = '{8'h01, 1'b1, 1'b0, 16'h0C05, 12};
        tbl[4] = '{8'hFF, 1'b0, 1'b1, 16'h07FD, 11};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 16'h0C01, 12};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 16'h0A01, 12};

        // reset held with DATA_VALID asserted
        reset      = 1'b0;
        DATA_VALID = 1'b1;
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        DATA_VALID = 1'b0;
        reset      = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_busy", {31'd0, Busy}, 32'd0);
            check("post_rst_tx", {31'd0, TX_OUT}, 32'd1);
        end

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].d, tbl[i].pe, tbl[i].pt, bits, len);
            check($sformatf("vec%0d_len", i), len, tbl[i].exp_len);
            check($sformatf("vec%0d_bits", i), {16'd0, bits},
                  {16'd0, tbl[i].exp_bits});
        end

        // back-to-back with DATA_VALID held high
        @(negedge clk);
        P_DATA     = 8'h11;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge clk);
        P_DATA = 8'hEE;
        capture(bits, len);
        check("b2b1_len", len, 11);
        check("b2b1_bits", {16'd0, bits}, 32'h0445);
        @(negedge clk);
        check("b2b_gap_busy", {31'd0, Busy}, 32'd1);
        DATA_VALID = 1'b0;
        P_DATA     = 8'h00;
        capture(bits, len);
        check("b2b2_len", len, 11);
        check("b2b2_bits", {16'd0, bits}, 32'h07B9);

        // async reset during data bit 4
        @(negedge clk);
        P_DATA     = 8'h10;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        @(negedge clk);
        DATA_VALID = 1'b0;
        repeat (6) @(negedge clk);
        check("d4_bit", {31'd0, TX_OUT}, 32'd1);
        check("d4_busy", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
        check("async_rst_busy", {31'd0, Busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_frame(8'h5A, 1'b1, 1'b1, bits, len);
        check("after_rst_len", len, 12);
        check("after_rst_bits", {16'd0, bits}, 32'h0D69);

        // loopback through a decoding RX model
        for (int b = 0; b < 256; b++) begin
            for (int c = 0; c < 4; c++) begin
                d  = 8'($urandom);
                pe = c[1];
                pt = c[0];
                run_frame(d, pe, pt, bits, len);
                check("lb_len", len, pe ? 12 : 11);
                check("lb_start", {31'd0, bits[1]}, 32'd0);
                check("lb_data", {24'd0, bits[9:2]}, {24'd0, d});
                if (pe)
                    check("lb_parity", {31'd0, bits[10]},
                          {31'd0, (^d) ^ pt});
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
